router_reg_pchk: RTL and testbench

//  Parametrised packet register for the 1x3 router datapath, next generation of the router register.

---
 rtl/router_reg_pchk.sv | 243 ++++++++++++++++++++++++
 tb/tb_router_reg_pchk.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_pchk.sv
// -----------------------------------------------------------------------------
// router_reg_pchk
//
// Packet register for the 1x3 router datapath. It sits between the source port
// and the destination FIFOs and is driven by the router FSM state strobes.
//   * latches the packet header on detect_add and replays it to the FIFO on
//     lfd_state;
//   * stages payload bytes and the trailing parity byte onto dout;
//   * parks a byte in a hold register while the selected FIFO is full and
//     replays it on laf_state;
//   * keeps a running XOR parity and a payload byte count, and flags a packet
//     whose parity byte or payload length does not match.
//
// Optional feature (compile-time macro ROUTER_REG_ERRCNT_EN):
//   When defined, an err_count_o port is added. It counts 0->1 transitions of
//   err_o, saturates at all-ones and is cleared only by resetn_i.
//   When undefined, the port and the counter do not exist.
//
// Parameters
//   DATA_W    data / header / parity width
//   ADDR_W    header address field width; the length field is the upper
//             LEN_W = DATA_W-ADDR_W bits of the header
//   ERRCNT_W  width of err_count_o (only with ROUTER_REG_ERRCNT_EN)
//
// Ports
//   clock_i              rising-edge clock
//   resetn_i             asynchronous active-low reset
//   pkt_valid_i          source byte valid; low while the parity byte is shown
//   data_in_i            source byte
//   fifo_full_i          selected destination FIFO is full
//   detect_add_i         FSM strobe: header on data_in_i
//   ld_state_i           FSM strobe: load payload / parity
//   laf_state_i          FSM strobe: load-after-full (drain hold register)
//   full_state_i         FSM strobe: FIFO-full wait
//   lfd_state_i          FSM strobe: load first data (header to FIFO)
//   rst_int_reg_i        clears low_packet_valid_o
//   dout_o               byte to FIFO
//   err_o                parity or length error of the completed packet
//   parity_done_o        packet parity byte captured
//   low_packet_valid_o   pkt_valid dropped during ld_state
//   err_count_o          errored-packet count (ROUTER_REG_ERRCNT_EN only)
// -----------------------------------------------------------------------------
module router_reg_pchk #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              pkt_valid_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              fifo_full_i,
    input  logic              detect_add_i,
    input  logic              ld_state_i,
    input  logic              laf_state_i,
    input  logic              full_state_i,
    input  logic              lfd_state_i,
    input  logic              rst_int_reg_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              err_o,
    output logic              parity_done_o,
    output logic              low_packet_valid_o
`ifdef ROUTER_REG_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count_o
`endif
);

    localparam int LEN_W = DATA_W - ADDR_W;

    // Saturation value of the payload counter (all ones).
    localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] dout_q,    dout_d;
    logic [DATA_W-1:0] hdr_q,     hdr_d;
    logic [DATA_W-1:0] hold_q,    hold_d;
    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic [LEN_W-1:0]  cnt_q,     cnt_d;
    logic              err_q,     err_d;
    logic              pdone_q,   pdone_d;
    logic              lpv_q,     lpv_d;
    // High for exactly the one cycle after parity_done rises; that is the
    // cycle in which the error verdict is formed.
    logic              err_eval_q, err_eval_d;

    // Length field of the latched header.
    logic [LEN_W-1:0]  hdr_len;
    assign hdr_len = hdr_q[DATA_W-1:ADDR_W];

    // Payload bytes are those presented in ld_state with pkt_valid high.
    // full_state is mutually exclusive with ld_state in normal operation; it
    // is still qualified here so a mis-sequenced FSM cannot double count.
    logic payload_beat;
    assign payload_beat = ld_state_i & pkt_valid_i & ~full_state_i;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        dout_d     = dout_q;
        hdr_d      = hdr_q;
        hold_d     = hold_q;
        int_par_d  = int_par_q;
        pkt_par_d  = pkt_par_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pdone_d    = pdone_q;
        lpv_d      = lpv_q;
        err_eval_d = 1'b0;

        // Verdict for the packet whose parity byte was captured last cycle.
        // Evaluated before the strobe decode so a detect_add in the same
        // cycle still clears err for the new packet.
        if (err_eval_q) begin
            err_d = (int_par_q != pkt_par_q) || (cnt_q != hdr_len);
        end

        // Strobe decode in priority order. A detect_add without pkt_valid is
        // a no-op and still masks the lower-priority strobes.
        if (detect_add_i) begin
            if (pkt_valid_i) begin
                hdr_d     = data_in_i;
                int_par_d = '0;
                cnt_d     = '0;
                err_d     = 1'b0;
                pdone_d   = 1'b0;
            end
        end else if (lfd_state_i) begin
            dout_d    = hdr_q;
            int_par_d = int_par_q ^ hdr_q;
        end else if (ld_state_i) begin
            // A byte arriving while the FIFO is full is parked, and dout keeps
            // showing the byte the FIFO has not yet accepted.
            if (fifo_full_i) begin
                hold_d = data_in_i;
            end else begin
                dout_d = data_in_i;
            end

            if (payload_beat) begin
                int_par_d = int_par_q ^ data_in_i;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Parity byte accepted directly by the FIFO.
            if (!pkt_valid_i && !fifo_full_i) begin
                pkt_par_d = data_in_i;
                pdone_d   = 1'b1;
            end

            if (!pkt_valid_i) begin
                lpv_d = 1'b1;
            end
        end else if (laf_state_i) begin
            dout_d = hold_q;
            // The parity byte itself was parked: it is captured from the hold
            // register when it is drained.
            if (lpv_q && !pdone_q) begin
                pkt_par_d = hold_q;
                pdone_d   = 1'b1;
            end
        end

        // rst_int_reg has the last word over the set above.
        if (rst_int_reg_i) begin
            lpv_d = 1'b0;
        end

        err_eval_d = pdone_d & ~pdone_q;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            dout_q     <= '0;
            hdr_q      <= '0;
            hold_q     <= '0;
            int_par_q  <= '0;
            pkt_par_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            pdone_q    <= 1'b0;
            lpv_q      <= 1'b0;
            err_eval_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            hdr_q      <= hdr_d;
            hold_q     <= hold_d;
            int_par_q  <= int_par_d;
            pkt_par_q  <= pkt_par_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pdone_q    <= pdone_d;
            lpv_q      <= lpv_d;
            err_eval_q <= err_eval_d;
        end
    end

    assign dout_o             = dout_q;
    assign err_o              = err_q;
    assign parity_done_o      = pdone_q;
    assign low_packet_valid_o = lpv_q;

`ifdef ROUTER_REG_ERRCNT_EN
    // -------------------------------------------------------------------------
    // Errored-packet counter. err is sticky per packet and cleared by the next
    // detect_add, so each errored packet produces exactly one rising edge.
    // The edge is taken from err_d so the count moves together with err_o.
    // -------------------------------------------------------------------------
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = {ERRCNT_W{1'b1}};

    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic                err_rise;

    assign err_rise = err_d & ~err_q;

    always_comb begin
        errcnt_d = errcnt_q;
        if (err_rise && (errcnt_q != ERRCNT_MAX)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_count_o = errcnt_q;
`endif

endmodule

// File: tb/tb_router_reg_pchk.sv
// -----------------------------------------------------------------------------
// tb_router_reg_pchk
//
// Bench for router_reg_pchk with DATA_W=8, ADDR_W=2 (ERRCNT_W=2 so the
// optional counter saturates quickly). A table of packet records is applied
// through a packet-sequencing task that plays the router FSM, followed by
// hand-written reset and counter sequences and a block of random packets whose
// expected error verdict comes from a packet-level model.
// -----------------------------------------------------------------------------
module tb_router_reg_pchk;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       err;
    logic       parity_done;
    logic       low_packet_valid;
`ifdef ROUTER_REG_ERRCNT_EN
    logic [1:0] err_count;
`endif

    router_reg_pchk #(
        .DATA_W  (8),
        .ADDR_W  (2),
        .ERRCNT_W(2)
    ) dut (
        .clock_i           (clk),
        .resetn_i          (resetn),
        .pkt_valid_i       (pkt_valid),
        .data_in_i         (data_in),
        .fifo_full_i       (fifo_full),
        .detect_add_i      (detect_add),
        .ld_state_i        (ld_state),
        .laf_state_i       (laf_state),
        .full_state_i      (full_state),
        .lfd_state_i       (lfd_state),
        .rst_int_reg_i     (rst_int_reg),
        .dout_o            (dout),
        .err_o             (err),
        .parity_done_o     (parity_done),
        .low_packet_valid_o(low_packet_valid)
`ifdef ROUTER_REG_ERRCNT_EN
        ,
        .err_count_o       (err_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // One packet record: header, up to 6 payload bytes (first byte in [7:0]),
    // parity byte, index of the byte that meets a full FIFO (-1 none, n means
    // the parity byte) and the expected error verdict.
    typedef struct {
        logic [7:0]  hdr;
        int          n;
        logic [47:0] pl;
        logic [7:0]  par;
        int          full_at;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %0h, expected %0h", tag, name, act, exp);
    endtask

    task automatic idle_inputs();
        pkt_valid   = 1'b0;
        data_in     = 8'h00;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        lfd_state   = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays one packet through the register the way the router FSM would and
    // checks dout at every step and the flags around parity capture.
    task automatic send_pkt(input string tag, input logic [7:0] hdr, input int n,
                            input logic [47:0] pl, input logic [7:0] par,
                            input int full_at, input logic exp_err);
        logic [7:0] prev;
        logic [7:0] b;

        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
        tick();
        check(tag, "err_clr_on_hdr", err, 1'b0);
        check(tag, "pdone_clr_on_hdr", parity_done, 1'b0);

        idle_inputs();
        lfd_state = 1'b1; pkt_valid = 1'b1; data_in = pl[7:0];
        tick();
        check(tag, "dout_hdr", dout, hdr);
        prev = hdr;

        for (int i = 0; i < n; i++) begin
            b = pl[8*i +: 8];
            idle_inputs();
            ld_state = 1'b1; pkt_valid = 1'b1; data_in = b;
            fifo_full = (i == full_at);
            tick();
            if (i == full_at) begin
                check(tag, "dout_stall", dout, prev);
                idle_inputs();
                full_state = 1'b1; fifo_full = 1'b1; pkt_valid = 1'b1; data_in = 8'hA5;
                tick();
                idle_inputs();
                laf_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h5A;
                tick();
            end
            check(tag, $sformatf("dout_pl%0d", i), dout, b);
            prev = b;
        end

        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b0; data_in = par;
        fifo_full = (full_at == n);
        tick();
        if (full_at == n) begin
            check(tag, "dout_par_stall", dout, prev);
            check(tag, "pdone_wait", parity_done, 1'b0);
            idle_inputs();
            full_state = 1'b1; fifo_full = 1'b1;
            tick();
            idle_inputs();
            laf_state = 1'b1;
            tick();
        end
        check(tag, "dout_par", dout, par);
        check(tag, "pdone_set", parity_done, 1'b1);
        check(tag, "lpv_set", low_packet_valid, 1'b1);
        check(tag, "err_not_yet", err, 1'b0);

        idle_inputs();
        tick();
        check(tag, "err_verdict", err, exp_err);

        idle_inputs();
        rst_int_reg = 1'b1;
        tick();
        check(tag, "lpv_clr", low_packet_valid, 1'b0);
        check(tag, "err_sticky", err, exp_err);

        idle_inputs();
        tick();
        check(tag, "dout_hold_idle", dout, par);
        check(tag, "pdone_hold_idle", parity_done, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r_hdr, r_par, x;
        logic [5:0]  r_len;
        logic [47:0] r_pl;
        int          r_n, r_full;
        logic        r_err;

        vecs[0] = '{hdr: 8'h0E, n: 3, pl: 48'h332211, par: 8'h0E, full_at: -1, exp_err: 1'b0};
        vecs[1] = '{hdr: 8'h0E, n: 3, pl: 48'h332211, par: 8'hFF, full_at: -1, exp_err: 1'b1};
        vecs[2] = '{hdr: 8'h12, n: 3, pl: 48'h332211, par: 8'h12, full_at: -1, exp_err: 1'b1};
        vecs[3] = '{hdr: 8'h0E, n: 3, pl: 48'h332211, par: 8'h0E, full_at:  1, exp_err: 1'b0};
        vecs[4] = '{hdr: 8'h01, n: 0, pl: 48'h0,      par: 8'h01, full_at: -1, exp_err: 1'b0};
        vecs[5] = '{hdr: 8'h0E, n: 3, pl: 48'h332211, par: 8'h0E, full_at:  3, exp_err: 1'b0};

        // ---------------- reset ----------------
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        check("reset", "dout", dout, 8'h00);
        check("reset", "err", err, 1'b0);
        check("reset", "pdone", parity_done, 1'b0);
        check("reset", "lpv", low_packet_valid, 1'b0);
`ifdef ROUTER_REG_ERRCNT_EN
        check("reset", "err_count", err_count, 2'd0);
`endif
        resetn = 1'b1;
        tick();

        // ---------------- table ----------------
        for (int v = 0; v < 6; v++) begin
            send_pkt($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].n, vecs[v].pl,
                     vecs[v].par, vecs[v].full_at, vecs[v].exp_err);
        end

        // ---------------- async reset while err is set ----------------
        send_pkt("bad_before_rst", 8'h0E, 3, 48'h332211, 8'hFF, -1, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("rst_idle", "err", err, 1'b0);
        check("rst_idle", "pdone", parity_done, 1'b0);
        check("rst_idle", "dout", dout, 8'h00);
        tick();
        resetn = 1'b1;

        // ---------------- async reset mid-packet ----------------
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0E;
        tick();
        idle_inputs();
        lfd_state = 1'b1; pkt_valid = 1'b1;
        tick();
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11;
        tick();
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h22;
        tick();
        check("rst_mid", "dout_before", dout, 8'h22);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid", "dout_async", dout, 8'h00);
        check("rst_mid", "lpv_async", low_packet_valid, 1'b0);
        idle_inputs();
        tick();
        resetn = 1'b1;
        tick();
        send_pkt("after_rst", 8'h0E, 3, 48'h332211, 8'h0E, -1, 1'b0);

`ifdef ROUTER_REG_ERRCNT_EN
        // ---------------- saturating error counter ----------------
        for (int k = 1; k <= 5; k++) begin
            send_pkt($sformatf("errcnt%0d", k), 8'h0E, 3, 48'h332211, 8'hFF, -1, 1'b1);
            check("errcnt", $sformatf("count_after_%0d", k), err_count,
                  (k > 3) ? 32'd3 : 32'(k));
        end
`endif

        // ---------------- random packets vs packet-level model ----------------
        for (int k = 0; k < 40; k++) begin
            r_n   = int'($urandom_range(0, 5));
            r_len = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 7)) : 6'(r_n);
            r_hdr = {r_len, 2'($urandom_range(0, 2))};
            r_pl  = {16'($urandom), 32'($urandom)};
            x = r_hdr;
            for (int i = 0; i < r_n; i++) x = x ^ r_pl[8*i +: 8];
            r_par  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : x;
            r_full = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, r_n)) : -1;
            r_err  = (r_par != x) || (int'(r_len) != r_n);
            send_pkt($sformatf("rnd%0d", k), r_hdr, r_n, r_pl, r_par, r_full, r_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
